// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button/switch inputs and conditioned outputs of button_conditioner
interface button_conditioner_if;
  // Raw asynchronous inputs
  logic P1;
  logic P2;
  logic D1;
  logic D2;
  // Conditioned outputs
  logic p1_pulse;
  logic p2_pulse;
  logic p1_level;
  logic p2_level;
  logic d1_level;
  logic d2_level;

  // Drives raw inputs, observes conditioned outputs
  modport master (
    output P1, P2, D1, D2,
    input  p1_pulse, p2_pulse, p1_level, p2_level, d1_level, d2_level
  );

  // The conditioner itself
  modport slave (
    input  P1, P2, D1, D2,
    output p1_pulse, p2_pulse, p1_level, p2_level, d1_level, d2_level
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise and debounce two buttons and two switches, press pulses for buttons
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  button_conditioner_if.slave btn
);

  typedef enum logic [1:0] {
    REL     = 2'd0,  // level 0, stable
    REL_CHK = 2'd1,  // level 0, synchronised input high being qualified
    PRS     = 2'd2,  // level 1, stable
    PRS_CHK = 2'd3   // level 1, synchronised input low being qualified
  } state_e;

  // Last count of a qualification window; reaching it with the input
  // still changed accepts the new level on that edge.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Channel order: 0=P1, 1=P2, 2=D1, 3=D2
  logic [3:0] raw;
  logic [3:0] level;
  logic [1:0] pulse;

  assign raw = {btn.D2, btn.D1, btn.P2, btn.P1};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Two-flop synchroniser bringing the raw input into the clk domain
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw[i];
        sync2_q <= sync1_q;
      end
    end

    // Debounce FSM next state: any reversal during a CHK state drops back
    // to the stable state and the window restarts from zero.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      case (state_q)
        REL: begin
          if (sync2_q) begin
            state_d = REL_CHK;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        REL_CHK: begin
          if (!sync2_q) begin
            state_d = REL;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRS;
            level_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        PRS: begin
          if (!sync2_q) begin
            state_d = PRS_CHK;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        PRS_CHK: begin
          if (sync2_q) begin
            state_d = PRS;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = REL;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    // Debounce FSM state, window counter and registered level
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= REL;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign level[i] = level_q;

    // Only the pushbutton channels produce press pulses
    if (i < 2) begin : g_pulse
      logic pulse_q;
      logic pulse_d;

      // Pulse on exactly the edge that accepts a press; release never pulses
      always_comb begin
        pulse_d = (state_q == REL_CHK) && sync2_q && (cnt_q == CNT_MAX);
      end

      // Registered one-cycle press pulse
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= pulse_d;
        end
      end

      assign pulse[i] = pulse_q;
    end
  end

  assign btn.p1_pulse = pulse[0];
  assign btn.p2_pulse = pulse[1];
  assign btn.p1_level = level[0];
  assign btn.p2_level = level[1];
  assign btn.d1_level = level[2];
  assign btn.d2_level = level[3];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed vector bench for button_conditioner
module tb_button_conditioner;

  logic clk;
  logic reset;
  int   applied;
  int   miscompares;

  button_conditioner_if bif ();

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {D2, D1, P2, P1}
  // exp = {d2_level, d1_level, p2_level, p1_level, p2_pulse, p1_pulse}
  typedef struct {
    logic [3:0] in;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] in, input int n, input logic [5:0] exp);
    vec_t v;
    v.in  = in;
    v.n   = n;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [3:0] in);
    bif.P1 = in[0];
    bif.P2 = in[1];
    bif.D1 = in[2];
    bif.D2 = in[3];
  endtask

  task automatic check(input string name, input int idx, input logic [5:0] exp);
    logic [5:0] got;
    got = {bif.d2_level, bif.d1_level, bif.p2_level, bif.p1_level, bif.p2_pulse, bif.p1_pulse};
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] t=%0t got %b want %b", name, idx, $time, got, exp);
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(4'b0000);

    // Idle
    add(4'b0000, 3,  6'b000000);
    // Clean P1 press held 20 cycles, then release
    add(4'b0001, 5,  6'b000000);
    add(4'b0001, 1,  6'b000101);
    add(4'b0001, 14, 6'b000100);
    add(4'b0000, 5,  6'b000100);
    add(4'b0000, 3,  6'b000000);
    // P1 bounce 1,0,1,0 then hold
    add(4'b0001, 1,  6'b000000);
    add(4'b0000, 1,  6'b000000);
    add(4'b0001, 1,  6'b000000);
    add(4'b0000, 1,  6'b000000);
    add(4'b0001, 5,  6'b000000);
    add(4'b0001, 1,  6'b000101);
    add(4'b0001, 4,  6'b000100);
    add(4'b0000, 5,  6'b000100);
    add(4'b0000, 3,  6'b000000);
    // P2 high only 3 cycles: rejected
    add(4'b0010, 3,  6'b000000);
    add(4'b0000, 6,  6'b000000);
    // P2 high exactly 4 cycles: accepted, pulse after input already gone
    add(4'b0010, 4,  6'b000000);
    add(4'b0000, 1,  6'b000000);
    add(4'b0000, 1,  6'b001010);
    add(4'b0000, 3,  6'b001000);
    add(4'b0000, 2,  6'b000000);
    // Simultaneous P1/P2 press
    add(4'b0011, 5,  6'b000000);
    add(4'b0011, 1,  6'b001111);
    add(4'b0011, 3,  6'b001100);
    add(4'b0000, 5,  6'b001100);
    add(4'b0000, 3,  6'b000000);
    // Switches: D1 up, 2-cycle D2 glitch, then D2 up, then both down
    add(4'b0100, 5,  6'b000000);
    add(4'b0100, 1,  6'b010000);
    add(4'b0100, 2,  6'b010000);
    add(4'b1100, 2,  6'b010000);
    add(4'b0100, 6,  6'b010000);
    add(4'b1100, 5,  6'b010000);
    add(4'b1100, 1,  6'b110000);
    add(4'b1100, 2,  6'b110000);
    add(4'b0000, 5,  6'b110000);
    add(4'b0000, 1,  6'b000000);
    add(4'b0000, 2,  6'b000000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 0, 6'b000000);
    reset = 1'b0;

    // Table-driven run
    for (int v = 0; v < vecs.size(); v++) begin
      for (int j = 0; j < vecs[v].n; j++) begin
        drive(vecs[v].in);
        @(posedge clk);
        #1;
        check("vec", v, vecs[v].exp);
      end
    end

    // All inputs high: qualify and catch the pulse cycle
    drive(4'b1111);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check("all_high", k, (k == 6) ? 6'b111111 : 6'b000000);
    end

    // Reset mid-pulse clears outputs without waiting for a clock edge
    reset = 1'b1;
    #1;
    check("async_reset", 0, 6'b000000);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      check("held_reset", k, 6'b000000);
    end

    // Inputs still high at release re-qualify as a fresh press
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      check("post_reset", k, (k == 6) ? 6'b111111 : ((k > 6) ? 6'b111100 : 6'b000000));
    end

    // Reset mid-qualification: no pulse leaks out afterwards while inputs low
    drive(4'b0000);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
    end
    drive(4'b0011);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    drive(4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("mid_qual_reset", k, 6'b000000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
